// File: rtl/pf_tile_fetch.sv
// rtl/pf_tile_fetch.sv - playfield tile fetch and 2bpp pixel serialiser; screen flip enabled by PF_FLIP_EN
module pf_tile_fetch #(
  parameter int COLS   = 32,
  parameter int ROWS   = 30,
  parameter int ROM_AW = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic [7:0]        vline,
  input  logic              flip,
  output logic [7:0]        pf_addr,
  input  logic [31:0]       pf_dout,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [1:0]        pixel,
  output logic              pix_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_ACTIVE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        vline_q, vline_d;
  logic              flip_q, flip_d;
  logic [4:0]        col_q, col_d;       // column currently being fetched
  logic [2:0]        ph_q, ph_d;
  logic              last_q, last_d;     // final column already fetched; no more fetches this line
  logic [1:0]        bank_q, bank_d;
  logic [7:0]        code_q, code_d;
  logic [15:0]       buf_q, buf_d;       // next-tile graphics {plane1, plane0}
  logic [7:0]        p0_q, p0_d;
  logic [7:0]        p1_q, p1_d;
  logic [1:0]        pixel_q, pixel_d;
  logic              pix_valid_q, pix_valid_d;
  logic [7:0]        pf_addr_q, pf_addr_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        line_sel;

`ifndef PF_FLIP_EN
  logic unused_flip;
  assign unused_flip = flip;
`endif

  // Tile index {row, col}, mirrored in both axes when flipped
  function automatic logic [9:0] tile_idx(input logic [4:0] row, input logic [4:0] col,
                                          input logic fl);
    logic [4:0] r;
    logic [4:0] c;
    r = fl ? (5'(ROWS - 1) - row) : row;
    c = fl ? (5'(COLS - 1) - col) : col;
    return {r, c};
  endfunction

  assign line_sel  = flip_q ? ~vline_q[2:0] : vline_q[2:0];
  assign pf_addr   = pf_addr_q;
  assign rom_addr  = rom_addr_q;
  assign pixel     = pixel_q;
  assign pix_valid = pix_valid_q;
  assign busy      = (state_q != S_IDLE);

  // Line sequencing, fetch pipeline and pixel serialiser
  always_comb begin
    state_d     = state_q;
    vline_d     = vline_q;
    flip_d      = flip_q;
    col_d       = col_q;
    ph_d        = ph_q;
    last_d      = last_q;
    bank_d      = bank_q;
    code_d      = code_q;
    buf_d       = buf_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    pixel_d     = pixel_q;
    pix_valid_d = pix_valid_q;
    pf_addr_d   = pf_addr_q;
    rom_addr_d  = rom_addr_q;

    if (line_start) begin
      // A new line always wins: drop any tile in flight and restart from column 0
      vline_d     = vline;
`ifdef PF_FLIP_EN
      flip_d      = flip;
`endif
      col_d       = 5'd0;
      ph_d        = 3'd0;
      last_d      = 1'b0;
      p0_d        = 8'd0;
      p1_d        = 8'd0;
      pixel_d     = 2'd0;
      pix_valid_d = 1'b0;
      if ({1'b0, vline[7:3]} < 6'(ROWS)) begin
        state_d = S_PREFETCH;
        {bank_d, pf_addr_d} = tile_idx(vline[7:3], 5'd0, flip_d);
        // A coincident strobe is consumed as the address phase of tile 0
        if (pix_ce) ph_d = 3'd1;
      end else begin
        state_d = S_IDLE;
      end
    end else if (pix_ce && (state_q != S_IDLE)) begin
      ph_d = ph_q + 3'd1;

      // Each memory read gets a whole phase to settle so the 1-clk RAM/ROM latency
      // is met even when pix_ce is high on every clock
      if (!last_q) begin
        case (ph_q)
          3'd0:    {bank_d, pf_addr_d} = tile_idx(vline_q[7:3], col_q, flip_q);
          3'd2:    code_d = pf_dout[{bank_q, 3'b000} +: 8];
          3'd3:    rom_addr_d = ROM_AW'({code_q, line_sel});
          3'd5:    buf_d = rom_data;
          default: ;
        endcase
      end

      if (state_q == S_ACTIVE) begin
        pixel_d = flip_q ? {p1_q[0], p0_q[0]} : {p1_q[7], p0_q[7]};
        p1_d    = flip_q ? (p1_q >> 1) : (p1_q << 1);
        p0_d    = flip_q ? (p0_q >> 1) : (p0_q << 1);
      end

      if (ph_q == 3'd7) begin
        if ((state_q == S_ACTIVE) && last_q) begin
          state_d     = S_IDLE;
          col_d       = 5'd0;
          last_d      = 1'b0;
          p0_d        = 8'd0;
          p1_d        = 8'd0;
          pixel_d     = 2'd0;
          pix_valid_d = 1'b0;
        end else begin
          // Present the first pixel of the buffered tile; the shifter keeps the other seven
          state_d     = S_ACTIVE;
          pix_valid_d = 1'b1;
          pixel_d     = flip_q ? {buf_q[8], buf_q[0]} : {buf_q[15], buf_q[7]};
          p1_d        = flip_q ? (buf_q[15:8] >> 1) : (buf_q[15:8] << 1);
          p0_d        = flip_q ? (buf_q[7:0] >> 1) : (buf_q[7:0] << 1);
          if (col_q == 5'(COLS - 1)) begin
            last_d = 1'b1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vline_q     <= 8'd0;
      flip_q      <= 1'b0;
      col_q       <= 5'd0;
      ph_q        <= 3'd0;
      last_q      <= 1'b0;
      bank_q      <= 2'd0;
      code_q      <= 8'd0;
      buf_q       <= 16'd0;
      p0_q        <= 8'd0;
      p1_q        <= 8'd0;
      pixel_q     <= 2'd0;
      pix_valid_q <= 1'b0;
      pf_addr_q   <= 8'd0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      vline_q     <= vline_d;
      flip_q      <= flip_d;
      col_q       <= col_d;
      ph_q        <= ph_d;
      last_q      <= last_d;
      bank_q      <= bank_d;
      code_q      <= code_d;
      buf_q       <= buf_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      pixel_q     <= pixel_d;
      pix_valid_q <= pix_valid_d;
      pf_addr_q   <= pf_addr_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

endmodule
